// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: status codes, icodes, register ids and FSM states.
package y86_pkg;

    localparam int unsigned NREGS  = 15;
    localparam int unsigned STAT_W = 3;
    localparam int unsigned REG_W  = 4;

    localparam logic [STAT_W-1:0] BUB = 3'd0;
    localparam logic [STAT_W-1:0] AOK = 3'd1;
    localparam logic [STAT_W-1:0] HLT = 3'd2;
    localparam logic [STAT_W-1:0] ADR = 3'd3;
    localparam logic [STAT_W-1:0] INS = 3'd4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;
    localparam logic [REG_W-1:0] RRSP  = 4'h4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

    function automatic logic is_fault(input logic [STAT_W-1:0] stat);
        return (stat == HLT) || (stat == ADR) || (stat == INS);
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// W pipeline register outputs presented to the writeback stage.
interface writeback_regfile_if #(
    parameter int unsigned DATA_W = 64
);
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;

    modport master (output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM);
    modport slave  (input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM);
endinterface

// File: rtl/y86_regfile.sv
// 15-entry program register file: two write ports (M wins on collision), two async read ports.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_e,
    input  logic [3:0]        dst_e,
    input  logic [DATA_W-1:0] val_e,
    input  logic              we_m,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] rval_a,
    output logic [DATA_W-1:0] rval_b
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Port M is applied last so it overrides port E on the same destination.
    always_comb begin
        regs_d = regs_q;
        if (we_e && (dst_e != RNONE)) regs_d[dst_e] = val_e;
        if (we_m && (dst_m != RNONE)) regs_d[dst_m] = val_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 32'(RRSP)) ? RSP_INIT : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rval_a = (src_a == RNONE) ? '0 : regs_q[src_a];
    assign rval_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: register commit, decode read ports, status/halt FSM and counters.
module writeback_regfile
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       CNT_W    = 32,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_regfile_if.slave  w,
    input  logic [3:0]          d_srcA,
    input  logic [3:0]          d_srcB,
    output logic [DATA_W-1:0]   d_rvalA,
    output logic [DATA_W-1:0]   d_rvalB,
    output logic [2:0]          Stat,
    output logic                halted,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
);

    wb_state_e         state_q, state_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  ins_q, ins_d;
    logic              we_e_c, we_m_c;

    // All W_* sampling is confined to RUN so garbage inputs in HALTED cannot move state.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        we_e_c  = 1'b0;
        we_m_c  = 1'b0;
        if (state_q == RUN) begin
            cyc_d  = cyc_q + CNT_W'(1);
            stat_d = (w.W_stat == BUB) ? AOK : w.W_stat;
            if (is_fault(w.W_stat)) state_d = HALTED;
            if (w.W_stat == AOK) begin
                we_e_c = (w.W_dstE != RNONE);
                we_m_c = (w.W_dstM != RNONE);
                if (w.W_icode != INOP) ins_d = ins_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            stat_q  <= AOK;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    y86_regfile #(
        .DATA_W   (DATA_W),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (we_e_c),
        .dst_e  (w.W_dstE),
        .val_e  (w.W_valE),
        .we_m   (we_m_c),
        .dst_m  (w.W_dstM),
        .val_m  (w.W_valM),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB)
    );

    assign Stat      = stat_q;
    assign halted    = (state_q == HALTED);
    assign cycle_cnt = cyc_q;
    assign instr_cnt = ins_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with 4-bit counters and a nonzero %rsp reset value.
module tb_writeback_regfile;
    import y86_pkg::*;

    localparam int unsigned       DATA_W   = 64;
    localparam int unsigned       CNT_W    = 4;
    localparam logic [DATA_W-1:0] RSP_INIT = 64'h8000;

    logic              clk;
    logic              rst_n;
    logic [3:0]        d_srcA, d_srcB;
    logic [DATA_W-1:0] d_rvalA, d_rvalB;
    logic [2:0]        Stat;
    logic              halted;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt;

    int n_checks;
    int n_fail;

    writeback_regfile_if #(.DATA_W(DATA_W)) w_if ();

    writeback_regfile #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .RSP_INIT (RSP_INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w         (w_if.slave),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .d_rvalA   (d_rvalA),
        .d_rvalB   (d_rvalB),
        .Stat      (Stat),
        .halted    (halted),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        w_if.W_stat  = st;
        w_if.W_icode = ic;
        w_if.W_dstE  = de;
        w_if.W_valE  = ve;
        w_if.W_dstM  = dm;
        w_if.W_valM  = vm;
    endtask

    task automatic idle();
        drive(BUB, INOP, RNONE, 64'h0, RNONE, 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [2:0] st, input logic h,
                                input logic [3:0] cyc, input logic [3:0] ins);
        check_eq({tag, "_stat"},  64'(Stat),      64'(st));
        check_eq({tag, "_halt"},  64'(halted),    64'(h));
        check_eq({tag, "_cycle"}, 64'(cycle_cnt), 64'(cyc));
        check_eq({tag, "_instr"}, 64'(instr_cnt), 64'(ins));
    endtask

    task automatic read_a(input logic [3:0] r, input string tag, input logic [63:0] exp);
        d_srcA = r;
        #1;
        check_eq(tag, d_rvalA, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        d_srcA   = RNONE;
        d_srcB   = RNONE;
        idle();

        // Reset values
        tick();
        tick();
        check_status("rst0", AOK, 1'b0, 4'd0, 4'd0);
        read_a(4'd4, "rst0_rsp", RSP_INIT);
        read_a(RNONE, "rst0_rnone", 64'h0);
        rst_n = 1'b1;

        // Single write: old value before the edge, new value after it
        drive(AOK, IRRMOVQ, 4'd3, 64'h1234, RNONE, 64'h0);
        read_a(4'd3, "wr_before_edge", 64'h0);
        tick();
        idle();
        read_a(4'd3, "wr_after_edge", 64'h1234);
        check_status("wr", AOK, 1'b0, 4'd1, 4'd1);

        // Same destination on both ports: valM wins
        drive(AOK, IPOPQ, 4'd4, 64'hAA, 4'd4, 64'hBB);
        tick();
        // Distinct destinations both written on one edge
        drive(AOK, IPOPQ, 4'd1, 64'h11, 4'd2, 64'h22);
        tick();
        idle();
        read_a(4'd4, "dual_same_r4", 64'hBB);
        read_a(4'd1, "dual_e_r1", 64'h11);
        d_srcB = 4'd2;
        #1;
        check_eq("dual_m_r2", d_rvalB, 64'h22);
        d_srcB = RNONE;
        check_status("dual", AOK, 1'b0, 4'd3, 4'd3);

        // Bubble: no write, Stat reads AOK, only cycle counter moves
        drive(BUB, IRRMOVQ, 4'd5, 64'hFF, RNONE, 64'h0);
        tick();
        idle();
        read_a(4'd5, "bub_r5", 64'h0);
        check_status("bub", AOK, 1'b0, 4'd4, 4'd3);

        // AOK nop retires without counting
        drive(AOK, INOP, RNONE, 64'h0, RNONE, 64'h0);
        tick();
        idle();
        check_status("nop", AOK, 1'b0, 4'd5, 4'd3);

        // Asynchronous reset mid-cycle with a write pending
        drive(AOK, IRRMOVQ, 4'd9, 64'h99, RNONE, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("midrst", AOK, 1'b0, 4'd0, 4'd0);
        for (int r = 0; r < 15; r++) begin
            read_a(4'(r), $sformatf("midrst_r%0d", r), (r == 4) ? RSP_INIT : 64'h0);
        end
        tick();
        idle();
        rst_n = 1'b1;

        // 16 retired instructions wrap both 4-bit counters back to 0
        for (int i = 0; i < 16; i++) begin
            drive(AOK, IIRMOVQ, 4'd0, 64'(i), RNONE, 64'h0);
            tick();
        end
        idle();
        read_a(4'd0, "wrap_r0", 64'd15);
        check_status("wrap", AOK, 1'b0, 4'd0, 4'd0);

        // Halt: halting edge counts a cycle, then everything freezes
        drive(HLT, IHALT, RNONE, 64'h0, RNONE, 64'h0);
        tick();
        check_status("hlt", HLT, 1'b1, 4'd1, 4'd0);
        drive(AOK, IRRMOVQ, 4'd6, 64'h66, 4'd6, 64'h67);
        tick();
        drive(BUB, IRRMOVQ, 4'd6, 64'h66, RNONE, 64'h0);
        tick();
        read_a(4'd6, "hlt_r6", 64'h0);
        check_status("hlt_frozen", HLT, 1'b1, 4'd1, 4'd0);

        // Reset pulse between edges returns to RUN
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check_status("hlt_rst", AOK, 1'b0, 4'd0, 4'd0);

        // Address fault: no write through dstM, halts with ADR
        drive(ADR, IMRMOVQ, RNONE, 64'h0, 4'd7, 64'h77);
        tick();
        idle();
        read_a(4'd7, "adr_r7", 64'h0);
        check_status("adr", ADR, 1'b1, 4'd1, 4'd0);
        tick();
        check_status("adr_hold", ADR, 1'b1, 4'd1, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
